datapath_controller: RTL
========================

Name: datapath_controller

Overview:
- Multi-cycle control sequencer that drives the DATAPATH register-file/ALU control interface: read_reg_num1, read_reg_num2, write_reg, alu_control and regwrite. It consumes zero_flag.
- Fetches 32-bit RISC-V-encoded instructions from a synchronous instruction ROM, decodes them into datapath controls, and sequences execution and writeback.
- Handles multi-cycle ALU ops (HCF, MUL) and a BEQ branch using zero_flag.
- Sits above DATAPATH and replaces hand-driven stimulus as the initiator of that interface.

Parameters:
PC_W, 10, byte-address width of the PC; imem word index is pc[PC_W-1:2]
RESET_PC, 0, PC value loaded on reset
HCF_LAT, 8, EXECUTE cycles held before writeback for HCF
MUL_LAT, 2, EXECUTE cycles held before writeback for MUL
CNT_W, 16, width of the retired-instruction counter

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  pulse; leaves IDLE and begins fetching at current pc
imem_addr  output  PC_W-2  word address to instruction ROM, registered
imem_rdata  input  32  instruction word, valid one cycle after imem_addr
read_reg_num1  output  5  rs1 to datapath
read_reg_num2  output  5  rs2 to datapath
write_reg  output  5  rd to datapath
alu_control  output  4  ALU op code to datapath
regwrite  output  1  register-file write enable, one-cycle pulse
zero_flag  input  1  ALU result == 0, from datapath
pc  output  PC_W  current program counter
busy  output  1  high in any state except IDLE/HALT
halted  output  1  high in HALT
illegal_instr  output  1  sticky; set on undecodable instruction, cleared by reset
retired_count  output  CNT_W  instructions completed, wraps modulo 2^CNT_W

Behaviour:
- Reset, synchronous, highest priority:
  - state=IDLE, pc=RESET_PC.
  - All control outputs, imem_addr, retired_count, illegal_instr and halted are 0.
  - Asserting reset mid-instruction drops regwrite at that same edge; no partial writeback occurs.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE -> FETCH on start=1. start is ignored in all other states.
- FETCH (1 cycle): imem_addr <= pc[PC_W-1:2]; -> DECODE.
- DECODE (1 cycle): latch imem_rdata and drive register fields: read_reg_num1=instr[19:15], read_reg_num2=instr[24:20], write_reg=instr[11:7]. Set alu_control and the wait count:
  - opcode 0110011, funct7 0000000: funct3 000 ADD 0010, 111 AND 0000, 110 OR 0001, 100 XOR 0111, 001 SLL 0011, 101 SRL 0101.
  - opcode 0110011, funct7 0100000, funct3 000: SUB 0100.
  - opcode 0110011, funct7 0000001, funct3 000: MUL 0110, wait MUL_LAT.
  - opcode 0001011 (custom-0), funct3 000: HCF 1001, wait HCF_LAT.
  - opcode 1100011, funct3 000: BEQ; alu_control=SUB 0100, no writeback.
  - 0x00000073: -> HALT.
  - Anything else: illegal_instr<=1; treat as NOP (pc+=4, not retired); -> FETCH.
- EXECUTE: controls held stable; wait counter counts 1 cycle for single-cycle ops, else MUL_LAT/HCF_LAT; -> WRITEBACK on expiry.
- WRITEBACK (1 cycle):
  - regwrite=1 only for ALU ops with rd!=0. rd=0 leaves regwrite=0 but the instruction still retires.
  - BEQ: zero_flag is sampled on this cycle. If 1, pc <= pc + sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}), else pc+4.
  - Non-branch: pc+4.
  - retired_count+1; -> FETCH.
- Control outputs change only on DECODE entry and are held through WRITEBACK.
- regwrite is never high outside WRITEBACK.
- PC arithmetic wraps modulo 2^PC_W. A branch target with bit1 set is truncated (bits[1:0] forced 0).
- HALT: all control outputs 0, halted=1, busy=0. Exit only via reset.
- Latency: single-cycle op 4 cycles/instr; MUL 3+MUL_LAT; HCF 3+HCF_LAT; BEQ 4.

Decomposition:
- Shared package `datapath_pkg`: ALU code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SUB, ALU_SRL, ALU_MUL, ALU_XOR, ALU_HCF), opcode/funct constants, state enum.
- One sub-module, `instr_decoder`: purely combinational instr -> {rs1, rs2, rd, alu_control, wait_sel, is_branch, is_halt, illegal, b_imm}.
- FSM, PC, wait counter and retired counter live in the top.

Test Plan:
- Reset then start; ROM[0]=ADD x10,x5,x6 (0x00628533) -> regwrite high exactly at cycle 4 after start; write_reg=10, alu_control=0010, pc=4, retired_count=1.
- ROM[0]=HCF x15,x12,x8 (custom-0, funct3 000), HCF_LAT=8 -> alu_control=1001 held 8 EXECUTE cycles, regwrite pulse at cycle 11, write_reg=15.
- BEQ x7,x7,+8 at pc=0 with zero_flag=1 -> pc=8. Repeat with zero_flag=0 -> pc=4. regwrite stays 0 throughout.
- ADD with rd=x0 -> regwrite never asserted; retired_count increments; pc=4.
- ROM word 0xFFFFFFFF then ECALL -> illegal_instr=1, pc advances to 4, then halted=1, busy=0, all controls 0; start ignored.
- Reset asserted during HCF EXECUTE cycle 3 -> next cycle state IDLE, pc=RESET_PC, regwrite=0, retired_count=0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared ALU codes, opcode/funct fields, FSM states and latched control bundle for the datapath sequencer.
// No logic, so no latency; no backpressure.
package datapath_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_MUL = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_HCF = 4'b1001;

    localparam logic [6:0] OP_RTYPE   = 7'b0110011;
    localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

    localparam logic [1:0] WAIT_ONE = 2'd0;
    localparam logic [1:0] WAIT_MUL = 2'd1;
    localparam logic [1:0] WAIT_HCF = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        wr_en;
        logic        is_branch;
        logic [12:0] b_imm;
    } ctrl_t;

endpackage

// File: rtl/datapath_controller_instr_decoder.sv
// Combinational decoder: instruction word to register fields, ALU code, wait class and branch immediate.
// Zero latency, output follows instr; no backpressure.
module instr_decoder
    import datapath_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [3:0]  alu_control,
    output logic [1:0]  wait_sel,
    output logic        is_branch,
    output logic        is_halt,
    output logic        illegal,
    output logic [12:0] b_imm
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];
    assign b_imm  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    always_comb begin
        alu_control = ALU_AND;
        wait_sel    = WAIT_ONE;
        is_branch   = 1'b0;
        is_halt     = 1'b0;
        illegal     = 1'b0;
        if (instr == INSTR_ECALL) begin
            is_halt = 1'b1;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct7)
                        F7_BASE: begin
                            case (funct3)
                                F3_ADD:  alu_control = ALU_ADD;
                                F3_AND:  alu_control = ALU_AND;
                                F3_OR:   alu_control = ALU_OR;
                                F3_XOR:  alu_control = ALU_XOR;
                                F3_SLL:  alu_control = ALU_SLL;
                                F3_SRL:  alu_control = ALU_SRL;
                                default: illegal = 1'b1;
                            endcase
                        end
                        F7_ALT: begin
                            if (funct3 == F3_ADD) alu_control = ALU_SUB;
                            else                  illegal = 1'b1;
                        end
                        F7_MULDIV: begin
                            if (funct3 == F3_ADD) begin
                                alu_control = ALU_MUL;
                                wait_sel    = WAIT_MUL;
                            end else begin
                                illegal = 1'b1;
                            end
                        end
                        default: illegal = 1'b1;
                    endcase
                end
                OP_CUSTOM0: begin
                    if (funct3 == F3_ADD) begin
                        alu_control = ALU_HCF;
                        wait_sel    = WAIT_HCF;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OP_BRANCH: begin
                    // BEQ compares by subtraction; the datapath reports equality via zero_flag
                    if (funct3 == F3_BEQ) begin
                        alu_control = ALU_SUB;
                        is_branch   = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/datapath_controller.sv
// Fetch/decode/execute/writeback sequencer driving the datapath register-file/ALU controls from an instruction ROM.
// 4 cycles per single-cycle op, 3+MUL_LAT / 3+HCF_LAT for MUL / HCF; no backpressure, start is a one-shot pulse.
module datapath_controller
    import datapath_pkg::*;
#(
    parameter int PC_W     = 10,
    parameter int RESET_PC = 0,
    parameter int HCF_LAT  = 8,
    parameter int MUL_LAT  = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [PC_W-3:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [4:0]        read_reg_num1,
    output logic [4:0]        read_reg_num2,
    output logic [4:0]        write_reg,
    output logic [3:0]        alu_control,
    output logic              regwrite,
    input  logic              zero_flag,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted,
    output logic              illegal_instr,
    output logic [CNT_W-1:0]  retired_count
);

    localparam int MAX_LAT = (HCF_LAT > MUL_LAT) ? HCF_LAT : MUL_LAT;
    localparam int WAIT_W  = $clog2(MAX_LAT + 1);

    state_t state;
    state_t state_nxt;

    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [4:0]  d_rd;
    logic [3:0]  d_alu;
    logic [1:0]  d_wait_sel;
    logic        d_branch;
    logic        d_halt;
    logic        d_illegal;
    logic [12:0] d_b_imm;

    ctrl_t              ctrl_dec;
    ctrl_t              ctrl_q;
    ctrl_t              ctrl_out;
    logic [WAIT_W-1:0]  wait_q;
    logic [WAIT_W-1:0]  wait_load;
    logic               wait_done;
    logic [PC_W-1:0]    pc_nxt;
    logic [PC_W-1:0]    pc_seq;
    logic [PC_W-1:0]    pc_br;

    instr_decoder u_decoder (
        .instr       (imem_rdata),
        .rs1         (d_rs1),
        .rs2         (d_rs2),
        .rd          (d_rd),
        .alu_control (d_alu),
        .wait_sel    (d_wait_sel),
        .is_branch   (d_branch),
        .is_halt     (d_halt),
        .illegal     (d_illegal),
        .b_imm       (d_b_imm)
    );

    // HALT and illegal words decode to an all-zero control bundle so nothing stale leaks out
    always_comb begin
        ctrl_dec = '0;
        if (!d_halt && !d_illegal) begin
            ctrl_dec.rs1       = d_rs1;
            ctrl_dec.rs2       = d_rs2;
            ctrl_dec.rd        = d_rd;
            ctrl_dec.alu       = d_alu;
            ctrl_dec.wr_en     = !d_branch && (d_rd != 5'd0);
            ctrl_dec.is_branch = d_branch;
            ctrl_dec.b_imm     = d_b_imm;
        end
    end

    always_comb begin
        case (d_wait_sel)
            WAIT_MUL: wait_load = WAIT_W'(MUL_LAT);
            WAIT_HCF: wait_load = WAIT_W'(HCF_LAT);
            default:  wait_load = WAIT_W'(1);
        endcase
    end

    assign wait_done = (wait_q == WAIT_W'(1));
    assign pc_seq    = pc + PC_W'(4);
    assign pc_br     = (pc + PC_W'($signed(ctrl_q.b_imm))) & ~PC_W'(3);

    always_comb begin
        pc_nxt = pc;
        if (state == ST_DECODE && d_illegal) begin
            pc_nxt = pc_seq;
        end else if (state == ST_WRITEBACK) begin
            pc_nxt = (ctrl_q.is_branch && zero_flag) ? pc_br : pc_seq;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start) state_nxt = ST_FETCH;
            ST_FETCH:     state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (d_halt)         state_nxt = ST_HALT;
                else if (d_illegal) state_nxt = ST_FETCH;
                else                state_nxt = ST_EXECUTE;
            end
            ST_EXECUTE:   if (wait_done) state_nxt = ST_WRITEBACK;
            ST_WRITEBACK: state_nxt = ST_FETCH;
            ST_HALT:      state_nxt = ST_HALT;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Word address is loaded on the way into FETCH so the ROM word lands at the start of DECODE
    always_ff @(posedge clock) begin
        if (reset) begin
            pc            <= PC_W'(RESET_PC);
            imem_addr     <= '0;
            ctrl_q        <= '0;
            wait_q        <= '0;
            illegal_instr <= 1'b0;
            retired_count <= '0;
        end else begin
            pc <= pc_nxt;
            if (state_nxt == ST_FETCH) imem_addr <= pc_nxt[PC_W-1:2];
            case (state)
                ST_DECODE: begin
                    ctrl_q <= ctrl_dec;
                    wait_q <= wait_load;
                    if (d_illegal) illegal_instr <= 1'b1;
                end
                ST_EXECUTE:   wait_q <= wait_q - WAIT_W'(1);
                ST_WRITEBACK: retired_count <= retired_count + CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        ctrl_out      = (state == ST_DECODE) ? ctrl_dec : ctrl_q;
        read_reg_num1 = ctrl_out.rs1;
        read_reg_num2 = ctrl_out.rs2;
        write_reg     = ctrl_out.rd;
        alu_control   = ctrl_out.alu;
        regwrite      = (state == ST_WRITEBACK) && ctrl_q.wr_en;
        busy          = (state != ST_IDLE) && (state != ST_HALT);
        halted        = (state == ST_HALT);
    end

endmodule
